data_valid: RTL and testbench

Frame validator for the QPSK receive path, placed after `iq_comb`. It deserialises the recovered bit stream, sampling one bit per `sync_flag` strobe. It then checks for the fixed 8-bit frame header and an 8-bit additive checksum. Frames that pass both checks are presented as a 40-bit parallel word with a one-cycle valid pulse.

---
 rtl/data_valid.sv | 114 +++++++++++
 tb/tb_data_valid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_valid.sv
// -----------------------------------------------------------------------------
// data_valid
//   Frame validator for the QPSK receive path (sits after iq_comb). Bits are
//   shifted into a 40-bit sliding window on every sync_flag strobe, LSB of the
//   frame first. One cycle after each shift the window is checked for the
//   8-bit header in [39:32] and, optionally, an 8-bit additive checksum in
//   [7:0]. A matching frame is published on valid_data_o with a one-cycle
//   valid_flag pulse.
//
//   Build option:
//     DATA_VALID_CKSUM_EN  defined   -> checksum [7:0] == sum of bytes 4..1
//                                       (mod 256) is part of the frame match
//                          undefined -> checksum ignored, no adder built
//
//   Ports:
//     clk           in   1   system clock, rising edge
//     rst_n         in   1   asynchronous active-low reset
//     ser_i         in   1   serial bit, meaningful only with sync_flag
//     sync_flag     in   1   bit strobe, one pulse per received bit
//     header_flag   out  1   pulse: window holds HEADER in [39:32]
//     valid_flag    out  1   pulse: header (and checksum) correct, 40 bits in
//     valid_data_o  out  40  last valid frame, held until the next one
// -----------------------------------------------------------------------------
module data_valid #(
   parameter logic [7:0] HEADER = 8'b1100_1100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ser_i,
   input  logic        sync_flag,
   output logic        header_flag,
   output logic        valid_flag,
   output logic [39:0] valid_data_o
);

   localparam logic [5:0] FRAME_LEN = 6'd40;
   localparam logic [5:0] HDR_LEN   = 6'd8;

   logic [39:0] win_q,   win_d;
   logic [5:0]  cnt_q,   cnt_d;
   logic        shift_q;
   logic        hdr_q,   hdr_d;
   logic        vld_q,   vld_d;
   logic [39:0] data_q,  data_d;

   logic        hdr_match;
   logic        frame_match;
   logic        cksum_ok;

   // Fill counter saturates at a full frame so it never wraps while idle.
   function automatic logic [5:0] cnt_sat_inc(input logic [5:0] c);
      if (c >= FRAME_LEN) return FRAME_LEN;
      else                return c + 6'd1;
   endfunction

`ifdef DATA_VALID_CKSUM_EN
   // 8-bit wrap-around sum over header and the three payload bytes.
   function automatic logic [7:0] frame_sum(input logic [39:0] w);
      return w[39:32] + w[31:24] + w[23:16] + w[15:8];
   endfunction

   assign cksum_ok = (frame_sum(win_q) == win_q[7:0]);
`else
   assign cksum_ok = 1'b1;
`endif

   // Detection only looks at the window in the cycle right after a shift, so
   // a long gap between strobes cannot produce repeated pulses.
   assign hdr_match   = shift_q && (win_q[39:32] == HEADER) && (cnt_q >= HDR_LEN);
   assign frame_match = hdr_match && cksum_ok && (cnt_q == FRAME_LEN);

   always_comb begin
      win_d  = win_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      hdr_d  = hdr_match;
      vld_d  = frame_match;

      // A detected frame restarts the fill count; a bit shifted on the same
      // edge is counted against the fresh frame.
      if (frame_match) begin
         cnt_d  = '0;
         data_d = win_q;
      end

      if (sync_flag) begin
         win_d = {ser_i, win_q[39:1]};
         cnt_d = cnt_sat_inc(frame_match ? 6'd0 : cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q   <= '0;
         cnt_q   <= '0;
         shift_q <= 1'b0;
         hdr_q   <= 1'b0;
         vld_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         shift_q <= sync_flag;
         hdr_q   <= hdr_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
      end
   end

   assign header_flag  = hdr_q;
   assign valid_flag   = vld_q;
   assign valid_data_o = data_q;

endmodule

// File: tb/tb_data_valid.sv
// -----------------------------------------------------------------------------
// tb_data_valid
//   Directed bench for data_valid: frames are shifted in LSB first, flag pulses
//   are counted on the falling edge and compared against hand-derived counts,
//   latency and output word.
// -----------------------------------------------------------------------------
module tb_data_valid;

   logic        clk;
   logic        rst_n;
   logic        ser_i;
   logic        sync_flag;
   logic        header_flag;
   logic        valid_flag;
   logic [39:0] valid_data_o;

   int checks;
   int failures;
   int cyc;
   int hdr_n;
   int vld_n;
   int vld_cyc;
   int last_strobe;

   localparam logic [40:0] DUMMY = '0;
   localparam logic [39:0] GOOD   = 40'hCC17181914;
   localparam logic [39:0] BADCK  = 40'hCC17181915;
   localparam logic [39:0] BADHDR = 40'hCD17181915;
   localparam logic [39:0] SECOND = 40'hCC01020310;

   data_valid dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ser_i        (ser_i),
      .sync_flag    (sync_flag),
      .header_flag  (header_flag),
      .valid_flag   (valid_flag),
      .valid_data_o (valid_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts high cycles, so a stretched pulse counts twice.
   always @(negedge clk) begin
      if (rst_n) begin
         if (header_flag) hdr_n <= hdr_n + 1;
         if (valid_flag) begin
            vld_n   <= vld_n + 1;
            vld_cyc <= cyc;
         end
      end
   end

   // Expected frame acceptance for the configured build.
   function automatic logic frame_ok(input logic [39:0] f);
`ifdef DATA_VALID_CKSUM_EN
      logic [7:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return (f[39:32] == 8'hCC) && (s == f[7:0]);
`else
      return (f[39:32] == 8'hCC);
`endif
   endfunction

   task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic send_bit(input logic b, input int gap, input bit rnd);
      ser_i     = b;
      sync_flag = 1'b1;
      @(negedge clk);
      sync_flag   = 1'b0;
      last_strobe = cyc;
      for (int k = 1; k < gap; k++) begin
         if (rnd) ser_i = 1'($urandom & 1);
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [39:0] f, input int nbits, input int gap, input bit rnd);
      for (int i = 0; i < nbits; i++) send_bit(f[i], gap, rnd);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int h0, v0;
      logic [39:0] exp_data;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      hdr_n     = 0;
      vld_n     = 0;
      vld_cyc   = 0;
      last_strobe = 0;
      rst_n     = 1'b0;
      ser_i     = 1'b0;
      sync_flag = 1'b0;

      // Reset state
      idle(2);
      check("rst_hdr",  40'(header_flag), 40'd0);
      check("rst_vld",  40'(valid_flag),  40'd0);
      check("rst_data", valid_data_o,     40'h0);
      rst_n = 1'b1;
      idle(1);

      // Good frame, strobe every 5 cycles
      h0 = hdr_n; v0 = vld_n;
      send_frame(GOOD, 40, 5, 1'b0);
      idle(3);
      check("good_hdr_cnt", 40'(hdr_n - h0), 40'd1);
      check("good_vld_cnt", 40'(vld_n - v0), 40'd1);
      check("good_latency", 40'(vld_cyc - last_strobe), 40'd1);
      check("good_data", valid_data_o, GOOD);

      // Bad checksum
      do_reset();
      h0 = hdr_n; v0 = vld_n;
      send_frame(BADCK, 40, 5, 1'b0);
      idle(3);
      exp_data = frame_ok(BADCK) ? BADCK : 40'h0;
      check("badck_hdr_cnt", 40'(hdr_n - h0), 40'd1);
      check("badck_vld_cnt", 40'(vld_n - v0), 40'(frame_ok(BADCK)));
      check("badck_data", valid_data_o, exp_data);

      // Bad header
      do_reset();
      h0 = hdr_n; v0 = vld_n;
      send_frame(BADHDR, 40, 5, 1'b0);
      idle(3);
      check("badhdr_hdr_cnt", 40'(hdr_n - h0), 40'd0);
      check("badhdr_vld_cnt", 40'(vld_n - v0), 40'd0);

      // Strobe gating: ser_i toggles randomly between strobes
      do_reset();
      h0 = hdr_n; v0 = vld_n;
      send_frame(GOOD, 40, 5, 1'b1);
      idle(3);
      check("gate_hdr_cnt", 40'(hdr_n - h0), 40'd1);
      check("gate_vld_cnt", 40'(vld_n - v0), 40'd1);
      check("gate_latency", 40'(vld_cyc - last_strobe), 40'd1);
      check("gate_data", valid_data_o, GOOD);

      // Back-to-back frames after 3 junk bits
      do_reset();
      h0 = hdr_n; v0 = vld_n;
      send_bit(1'b1, 5, 1'b0);
      send_bit(1'b0, 5, 1'b0);
      send_bit(1'b1, 5, 1'b0);
      send_frame(GOOD, 40, 5, 1'b0);
      send_frame(SECOND, 40, 5, 1'b0);
      idle(3);
      exp_data = frame_ok(SECOND) ? SECOND : GOOD;
      check("b2b_hdr_cnt", 40'(hdr_n - h0), 40'd2);
      check("b2b_vld_cnt", 40'(vld_n - v0), 40'(1 + int'(frame_ok(SECOND))));
      check("b2b_data", valid_data_o, exp_data);

      // Asynchronous reset after 20 bits, then a full good frame
      h0 = hdr_n; v0 = vld_n;
      send_frame(GOOD, 20, 5, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_data", valid_data_o,     40'h0);
      check("midrst_hdr",  40'(header_flag), 40'd0);
      check("midrst_vld",  40'(valid_flag),  40'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      send_frame(GOOD, 40, 5, 1'b0);
      idle(3);
      check("midrst_vld_cnt", 40'(vld_n - v0), 40'd1);
      check("midrst_hdr_cnt", 40'(hdr_n - h0), 40'd1);
      check("midrst_final",   valid_data_o,    GOOD);

      // Continuous strobe: second frame starts on the same edge the first
      // frame is reported, so the fill count must restart at 1.
      do_reset();
      h0 = hdr_n; v0 = vld_n;
      send_frame(GOOD, 40, 1, 1'b0);
      send_frame(GOOD, 40, 1, 1'b0);
      idle(4);
      check("cont_hdr_cnt", 40'(hdr_n - h0), 40'd2);
      check("cont_vld_cnt", 40'(vld_n - v0), 40'd2);
      check("cont_data", valid_data_o, GOOD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
